// File: rtl/exec_muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide execution unit:
// funct3 op codes, the R-type M-extension funct7 and the FSM state type.
package exec_muldiv_pkg;

    localparam logic [2:0] INST_MUL    = 3'b000;
    localparam logic [2:0] INST_MULH   = 3'b001;
    localparam logic [2:0] INST_MULHSU = 3'b010;
    localparam logic [2:0] INST_MULHU  = 3'b011;
    localparam logic [2:0] INST_DIV    = 3'b100;
    localparam logic [2:0] INST_DIVU   = 3'b101;
    localparam logic [2:0] INST_REM    = 3'b110;
    localparam logic [2:0] INST_REMU   = 3'b111;

    localparam logic [6:0] INST_TYPE_R_M = 7'b0000001;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_MUL,
        MD_DIV,
        MD_FIX,
        MD_DONE
    } md_state_e;

endpackage

// File: rtl/div_iter_core.sv
// Restoring divider on unsigned magnitudes; each step retires DIV_BITS
// quotient bits. done flags the cycle in which the final step executes.
module div_iter_core #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DIV_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int unsigned STEPS = XLEN / DIV_BITS;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] r, q;
    logic [XLEN:0]   r_ext;

    // quo_q doubles as the dividend shift register: its MSBs feed the
    // partial remainder while quotient bits enter at the LSB.
    always_comb begin
        r     = rem_q;
        q     = quo_q;
        r_ext = '0;
        for (int unsigned i = 0; i < DIV_BITS; i++) begin
            r_ext = {r, q[XLEN-1]};
            q     = {q[XLEN-2:0], 1'b0};
            if (r_ext >= {1'b0, dvs_q}) begin
                r_ext = r_ext - {1'b0, dvs_q};
                q[0]  = 1'b1;
            end
            r = r_ext[XLEN-1:0];
        end
        rem_d = r;
        quo_d = q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= '0;
        end else if (step) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign done      = (cnt_q == LAST);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/exec_muldiv.sv
// RV32M execution unit: pipelined multiplier and iterative divider behind one FSM.
// MULDIV_FAST_SPECIAL_EN: divide-by-zero / signed overflow finish straight from IDLE.
module exec_muldiv
    import exec_muldiv_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_STAGES = 2,
    parameter int unsigned DIV_BITS   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush,
    output logic            busy,
    output logic            hold_en,
    output logic            result_valid,
    output logic [XLEN-1:0] rd_data,
    output logic [4:0]      rd_addr_o
);

    localparam logic [1:0] MUL_LAST = 2'(MUL_STAGES - 2);

    md_state_e state_q, state_d;

    logic [2:0]        funct3_q;
    logic [4:0]        rd_addr_q;
    logic [XLEN-1:0]   rd_data_q, div_res_q, result;
    logic [1:0]        mul_cnt_q;
    logic              dz_q, q_neg_q, r_neg_q;
    logic [2*XLEN-1:0] mul_pipe_q [MUL_STAGES];
    logic [2*XLEN-1:0] a_ext, b_ext, mul_prod;
    logic [XLEN-1:0]   a_mag, b_mag, quo, rem, div_fix;
    logic              accept, div_signed, div_done, fast_special;

    assign accept     = (state_q == MD_IDLE) & start & ~flush;
    assign div_signed = ~funct3[0];

    // Operands extended to full product width; truncating the product to
    // 2*XLEN is exact for every signed/unsigned combination.
    assign a_ext    = {{XLEN{(funct3[1:0] != 2'b11) & op1[XLEN-1]}}, op1};
    assign b_ext    = {{XLEN{~funct3[1] & op2[XLEN-1]}}, op2};
    assign mul_prod = a_ext * b_ext;

    assign a_mag = (div_signed & op1[XLEN-1]) ? -op1 : op1;
    assign b_mag = (div_signed & op2[XLEN-1]) ? -op2 : op2;

`ifdef MULDIV_FAST_SPECIAL_EN
    assign fast_special = funct3[2] &
        ((op2 == '0) |
         (div_signed & (op1 == {1'b1, {(XLEN-1){1'b0}}}) & (op2 == '1)));
`else
    assign fast_special = 1'b0;
`endif

    div_iter_core #(
        .XLEN     (XLEN),
        .DIV_BITS (DIV_BITS)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (accept & funct3[2]),
        .step      (state_q == MD_DIV),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= MD_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MD_IDLE: begin
                if (accept) begin
                    if (funct3[2])            state_d = fast_special ? MD_DONE : MD_DIV;
                    else if (MUL_STAGES == 1) state_d = MD_DONE;
                    else                      state_d = MD_MUL;
                end
            end
            MD_MUL:  if (flush) state_d = MD_IDLE; else if (mul_cnt_q == MUL_LAST) state_d = MD_DONE;
            MD_DIV:  if (flush) state_d = MD_IDLE; else if (div_done) state_d = MD_FIX;
            MD_FIX:  state_d = flush ? MD_IDLE : MD_DONE;
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != MD_IDLE);
        result_valid = (state_q == MD_DONE);
        hold_en      = (start & (state_q == MD_IDLE)) | (busy & ~result_valid);
        if (funct3_q[2])                 result = div_res_q;
        else if (funct3_q[1:0] == 2'b00) result = mul_pipe_q[MUL_STAGES-1][XLEN-1:0];
        else                             result = mul_pipe_q[MUL_STAGES-1][2*XLEN-1:XLEN];
        rd_data      = result_valid ? result : rd_data_q;
        rd_addr_o    = rd_addr_q;
    end

    // Divide-by-zero quotient is forced; its remainder falls out of the
    // magnitude path with the dividend's sign restored.
    always_comb begin
        if (funct3_q[1]) div_fix = r_neg_q ? -rem : rem;
        else if (dz_q)   div_fix = '1;
        else             div_fix = q_neg_q ? -quo : quo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_q  <= '0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            div_res_q <= '0;
            mul_cnt_q <= '0;
            dz_q      <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            for (int unsigned k = 0; k < MUL_STAGES; k++) mul_pipe_q[k] <= '0;
        end else begin
            for (int unsigned k = 1; k < MUL_STAGES; k++) mul_pipe_q[k] <= mul_pipe_q[k-1];
            if (state_q == MD_MUL) mul_cnt_q <= mul_cnt_q + 2'd1;
            if (accept) begin
                funct3_q      <= funct3;
                rd_addr_q     <= rd_addr_i;
                mul_pipe_q[0] <= mul_prod;
                mul_cnt_q     <= '0;
                dz_q          <= (op2 == '0);
                q_neg_q       <= div_signed & (op1[XLEN-1] ^ op2[XLEN-1]);
                r_neg_q       <= div_signed & op1[XLEN-1];
                if (fast_special) begin
                    if (funct3[1]) div_res_q <= (op2 == '0) ? op1 : '0;
                    else           div_res_q <= (op2 == '0) ? '1 : op1;
                end
            end
            if (state_q == MD_FIX)  div_res_q <= div_fix;
            if (state_q == MD_DONE) rd_data_q <= result;
        end
    end

endmodule

// File: tb/tb_exec_muldiv.sv
// Directed self-checking bench for exec_muldiv: values, latencies, flush, reset, start-while-busy.
module tb_exec_muldiv;
    import exec_muldiv_pkg::*;

`ifdef MULDIV_FAST_SPECIAL_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 34;
`endif
    localparam int DIV_LAT = 34;
    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  funct3;
    logic [31:0] op1, op2;
    logic [4:0]  rd_addr_i;
    logic        busy, hold_en, result_valid;
    logic [31:0] rd_data;
    logic [4:0]  rd_addr_o;

    int errors = 0;
    int checks = 0;

    exec_muldiv #(
        .XLEN       (32),
        .MUL_STAGES (2),
        .DIV_BITS   (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .funct3       (funct3),
        .op1          (op1),
        .op2          (op2),
        .rd_addr_i    (rd_addr_i),
        .flush        (flush),
        .busy         (busy),
        .hold_en      (hold_en),
        .result_valid (result_valid),
        .rd_data      (rd_data),
        .rd_addr_o    (rd_addr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        start = 1'b1; funct3 = f3; op1 = a; op2 = b; rd_addr_i = rd;
    endtask

    // Counts negedges until result_valid is seen; bounded.
    task automatic wait_rv(input int lat0, output int lat);
        lat = lat0;
        do begin
            @(negedge clk);
            lat++;
        end while (!result_valid && lat < 200);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(f3, a, b, rd);
        #1 check({tag, "_hold"}, 32'(hold_en), 32'd1);
        @(posedge clk);
        #1 start = 1'b0;
        wait_rv(0, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, rd_data, exp);
        check({tag, "_addr"}, 32'(rd_addr_o), 32'(rd));
    endtask

    initial begin
        int lat, pulses;
        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op1 = '0; op2 = '0; rd_addr_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hold", 32'(hold_en), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_data", rd_data, 32'd0);
        check("rst_addr", 32'(rd_addr_o), 32'd0);

        run_op("mul", INST_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, MUL_LAT);
        check("done_hold", 32'(hold_en), 32'd0);
        // Issued in the cycle right after DONE.
        run_op("mul_b2b", INST_MUL, 32'd6, 32'd9, 5'd2, 32'd54, MUL_LAT);
        run_op("mulhu", INST_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulh", INST_MULH, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, MUL_LAT);
        run_op("mulhsu", INST_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd5, 32'hFFFF_FFFF, MUL_LAT);

        run_op("div", INST_DIV, 32'hFFFF_FFEC, 32'd3, 5'd6, 32'hFFFF_FFFA, DIV_LAT);
        run_op("rem", INST_REM, 32'hFFFF_FFEC, 32'd3, 5'd7, 32'hFFFF_FFFE, DIV_LAT);
        run_op("divu", INST_DIVU, 32'd100, 32'd7, 5'd8, 32'd14, DIV_LAT);
        run_op("remu", INST_REMU, 32'd100, 32'd7, 5'd9, 32'd2, DIV_LAT);
        run_op("div0", INST_DIV, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, SPEC_LAT);
        run_op("remu0", INST_REMU, 32'd5, 32'd0, 5'd11, 32'd5, SPEC_LAT);
        run_op("divneg0", INST_DIV, 32'hFFFF_FFFB, 32'd0, 5'd12, 32'hFFFF_FFFF, SPEC_LAT);
        run_op("remneg0", INST_REM, 32'hFFFF_FFFB, 32'd0, 5'd13, 32'hFFFF_FFFB, SPEC_LAT);
        run_op("divovf", INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, SPEC_LAT);
        run_op("removf", INST_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, SPEC_LAT);
        run_op("divu_big", INST_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, DIV_LAT);
        run_op("remu_big", INST_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, DIV_LAT);

        // start held while busy must not launch a second op.
        issue(INST_DIVU, 32'd100, 32'd7, 5'd3);
        @(posedge clk);
        #1 funct3 = INST_MUL; op1 = 32'd2; op2 = 32'd2; rd_addr_i = 5'd9;
        repeat (4) @(negedge clk);
        start = 1'b0;
        wait_rv(4, lat);
        check("ign_lat", 32'(lat), 32'd34);
        check("ign_data", rd_data, 32'd14);
        check("ign_addr", 32'(rd_addr_o), 32'd3);
        @(negedge clk);
        check("ign_valid_pulse", 32'(result_valid), 32'd0);
        check("ign_busy_after", 32'(busy), 32'd0);

        // Flush in the middle of a divide.
        issue(INST_DIVU, 32'd100, 32'd7, 5'd20);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_hold", 32'(hold_en), 32'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid) pulses++;
        end
        check("flush_nopulse", 32'(pulses), 32'd0);
        check("flush_data_kept", rd_data, 32'd14);

        // Flush wins over start in IDLE.
        issue(INST_MUL, 32'd3, 32'd3, 5'd21);
        flush = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_start_busy", 32'(busy), 32'd0);

        // Reset in the middle of a multiply.
        issue(INST_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 5'd22);
        @(posedge clk);
        #1 start = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_valid", 32'(result_valid), 32'd0);
        check("rstmid_data", rd_data, 32'd0);
        check("rstmid_addr", 32'(rd_addr_o), 32'd0);
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (result_valid) pulses++;
        end
        check("rstmid_nopulse", 32'(pulses), 32'd0);

        run_op("mul_after_rst", INST_MUL, 32'd11, 32'd13, 5'd23, 32'd143, MUL_LAT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
